// File: rtl/reg_file_pkg.sv
// Shared definitions for the pipelined register file.
// Contents:
//   DEF_DATA_W / DEF_DEPTH        default word width and register count
//   DEF_MULT_REG / DEF_MEMA_REG / DEF_CTRL_REG  dedicated register indices
//   reg_word_t                    one register word at the default width
//   wr_stage_t                    one write-pipeline stage at the default sizes
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_MULT_REG = 13;
    localparam int unsigned DEF_MEMA_REG = 14;
    localparam int unsigned DEF_CTRL_REG = 15;

    typedef logic [DEF_DATA_W-1:0] reg_word_t;

    typedef struct packed {
        logic [DEF_DEPTH-1:0] mask;
        reg_word_t            d;
        reg_word_t            mult;
    } wr_stage_t;

endpackage

// File: rtl/reg_file_pipe_if.sv
// Bus bundle for reg_file_pipe.
// Signals:
//   d, mult_high   write data (mult_high feeds only the multiplier-high register)
//   en_n           active-low per-register write enables
//   rd_addr        packed read addresses, port k in slice k
//   rd_data        packed registered read data, port k in slice k
//   pending        per-register "write accepted but not yet committed"
//   q              packed committed register values, register i in slice i
//   ctrl, mema_top dedicated register taps
// Modports: master drives writes/addresses, slave is the register file.
interface reg_file_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_RD = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0]        d;
    logic [DATA_W-1:0]        mult_high;
    logic [DEPTH-1:0]         en_n;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DEPTH-1:0]         pending;
    logic [DEPTH*DATA_W-1:0]  q;
    logic [DATA_W-1:0]        ctrl;
    logic [DATA_W-1:0]        mema_top;

    modport master (
        output d, mult_high, en_n, rd_addr,
        input  rd_data, pending, q, ctrl, mema_top
    );

    modport slave (
        input  d, mult_high, en_n, rd_addr,
        output rd_data, pending, q, ctrl, mema_top
    );

endinterface

// File: rtl/wr_stage_pipe.sv
// WR_LAT-deep write pipeline. Each stage carries a register mask plus both
// candidate data words; stages advance every cycle with no stall.
// Ports:
//   clk, rst_n      clock, synchronous active-low clear of all stages
//   in_mask/in_d/in_mult     write captured into the first stage
//   commit_mask/commit_d/commit_mult  last stage, applied at the next edge
//   any_mask        OR of every stage mask (drives pending)
module wr_stage_pipe
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DEPTH-1:0]  in_mask,
    input  logic [DATA_W-1:0] in_d,
    input  logic [DATA_W-1:0] in_mult,
    output logic [DEPTH-1:0]  commit_mask,
    output logic [DATA_W-1:0] commit_d,
    output logic [DATA_W-1:0] commit_mult,
    output logic [DEPTH-1:0]  any_mask
);

    typedef struct packed {
        logic [DEPTH-1:0]  mask;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] mult;
    } stage_t;

    stage_t stage_q [WR_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WR_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_t'{mask: in_mask, d: in_d, mult: in_mult};
            for (int unsigned i = 1; i < WR_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign commit_mask = stage_q[WR_LAT-1].mask;
    assign commit_d    = stage_q[WR_LAT-1].d;
    assign commit_mult = stage_q[WR_LAT-1].mult;

    always_comb begin
        any_mask = '0;
        for (int unsigned i = 0; i < WR_LAT; i++) begin
            any_mask |= stage_q[i].mask;
        end
    end

endmodule

// File: rtl/reg_file_pipe.sv
// Parametrised register file with a WR_LAT-cycle write-commit pipeline, a
// pending-write scoreboard and NUM_RD registered, write-first read ports.
// Ports:
//   clk    sole clock
//   rst_n  synchronous active-low reset (clears registers, reads and pipeline)
//   bus    reg_file_pipe_if slave: d, mult_high, en_n, rd_addr in;
//          rd_data, pending, q, ctrl, mema_top out
module reg_file_pipe
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned WR_LAT   = 1,
    parameter int unsigned MULT_REG = DEF_MULT_REG,
    parameter int unsigned MEMA_REG = DEF_MEMA_REG,
    parameter int unsigned CTRL_REG = DEF_CTRL_REG
) (
    input logic           clk,
    input logic           rst_n,
    reg_file_pipe_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (WR_LAT < 1 || WR_LAT > 4) begin : g_bad_wr_lat
        $fatal(1, "reg_file_pipe: WR_LAT must be 1..4");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $fatal(1, "reg_file_pipe: NUM_RD must be 1..4");
    end
    if (DEPTH < 4 || MULT_REG >= DEPTH || MEMA_REG >= DEPTH || CTRL_REG >= DEPTH)
    begin : g_bad_index
        $fatal(1, "reg_file_pipe: DEPTH too small or dedicated index out of range");
    end
    if (MULT_REG == MEMA_REG || MULT_REG == CTRL_REG || MEMA_REG == CTRL_REG)
    begin : g_dup_index
        $fatal(1, "reg_file_pipe: dedicated register indices must differ");
    end

    logic [DEPTH-1:0]  commit_mask;
    logic [DATA_W-1:0] commit_d;
    logic [DATA_W-1:0] commit_mult;
    logic [DEPTH-1:0]  inflight;

    wr_stage_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .WR_LAT (WR_LAT)
    ) u_wr_stage_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_mask     (~bus.en_n),
        .in_d        (bus.d),
        .in_mult     (bus.mult_high),
        .commit_mask (commit_mask),
        .commit_d    (commit_d),
        .commit_mult (commit_mult),
        .any_mask    (inflight)
    );

    assign bus.pending = inflight;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // regs_d is the post-edge register image; read ports sample it so a
    // commit at the same edge is forwarded.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (commit_mask[i]) begin
                regs_d[i] = (i == MULT_REG) ? commit_mult : commit_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= rst_n ? regs_d[i] : '0;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_q
        assign bus.q[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign bus.ctrl     = regs_q[CTRL_REG];
    assign bus.mema_top = regs_q[MEMA_REG];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign addr = bus.rd_addr[k*AW +: AW];

        // Compare-select mux; addresses >= DEPTH match nothing and read 0.
        always_comb begin
            rd_d = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (addr == AW'(j)) begin
                    rd_d = regs_d[j];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_reg_file_pipe.sv
// Self-checking bench for reg_file_pipe: three instances with WR_LAT of 1, 3
// and 4 share clock and reset. A vector table exercises the WR_LAT=1 part;
// hand-written sequences cover the longer latencies and mid-flight reset.
module tb_reg_file_pipe;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_pipe_if #(.DATA_W(8), .DEPTH(16), .NUM_RD(2)) b1 ();
    reg_file_pipe_if #(.DATA_W(8), .DEPTH(16), .NUM_RD(2)) b3 ();
    reg_file_pipe_if #(.DATA_W(8), .DEPTH(16), .NUM_RD(2)) b4 ();

    reg_file_pipe #(.WR_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    reg_file_pipe #(.WR_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    reg_file_pipe #(.WR_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_word_t qw(input logic [127:0] qv, input int idx);
        return qv[idx*8 +: 8];
    endfunction

    function automatic logic [15:0] nz_mask(input logic [127:0] qv);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = |qv[i*8 +: 8];
        return m;
    endfunction

    typedef struct {
        logic [15:0] en_n;
        reg_word_t   d;
        reg_word_t   mult;
        logic [7:0]  rd_addr;   // {port1, port0}
        logic [15:0] exp_pend;
        int          q_idx;
        reg_word_t   exp_q;
        logic [15:0] exp_nz;
        logic [15:0] exp_rd;    // {port1, port0}
        reg_word_t   exp_ctrl;
        reg_word_t   exp_mema;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Expected values hold after the edge that samples the row's inputs.
        vecs[0] = '{16'hFFFE, 8'hA5, 8'h00, 8'h00, 16'h0001,  0, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00};
        vecs[1] = '{16'hFFFF, 8'h00, 8'h00, 8'h00, 16'h0000,  0, 8'hA5, 16'h0001, 16'hA5A5, 8'h00, 8'h00};
        vecs[2] = '{16'hDFFF, 8'h11, 8'h7C, 8'h0D, 16'h2000, 13, 8'h00, 16'h0001, 16'hA500, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 8'h00, 8'h00, 8'h0D, 16'h0000, 13, 8'h7C, 16'h2001, 16'hA57C, 8'h00, 8'h00};
        vecs[4] = '{16'h3FFF, 8'h3C, 8'h55, 8'hEF, 16'hC000, 15, 8'h00, 16'h2001, 16'h0000, 8'h00, 8'h00};
        vecs[5] = '{16'h7FFF, 8'h01, 8'h00, 8'hEF, 16'h8000, 15, 8'h3C, 16'hE001, 16'h3C3C, 8'h3C, 8'h3C};
        vecs[6] = '{16'h7FFF, 8'h02, 8'h00, 8'hEF, 16'h8000, 15, 8'h01, 16'hE001, 16'h3C01, 8'h01, 8'h3C};
        vecs[7] = '{16'hFFFF, 8'h00, 8'h00, 8'hEF, 16'h0000, 15, 8'h02, 16'hE001, 16'h3C02, 8'h02, 8'h3C};
        vecs[8] = '{16'h0000, 8'hFF, 8'hEE, 8'h5D, 16'hFFFF, 13, 8'h7C, 16'hE001, 16'h007C, 8'h02, 8'h3C};
        vecs[9] = '{16'hFFFF, 8'h00, 8'h00, 8'h5D, 16'h0000, 13, 8'hEE, 16'hFFFF, 16'hFFEE, 8'hFF, 8'hFF};

        b1.en_n = '1; b1.d = '0; b1.mult_high = '0; b1.rd_addr = '0;
        b3.en_n = '1; b3.d = '0; b3.mult_high = '0; b3.rd_addr = '0;
        b4.en_n = '1; b4.d = '0; b4.mult_high = '0; b4.rd_addr = '0;

        // Reset for two edges
        rst_n = 1'b0;
        tick();
        tick();
        check("rst q1", b1.q, '0);
        check("rst q3", b3.q, '0);
        check("rst q4", b4.q, '0);
        check("rst ctrl", b1.ctrl, '0);
        check("rst mema", b1.mema_top, '0);
        check("rst pending", b1.pending | b3.pending | b4.pending, '0);
        check("rst rd_data", b1.rd_data | b3.rd_data | b4.rd_data, '0);
        rst_n = 1'b1;

        // Table: WR_LAT=1 instance
        for (int i = 0; i < 10; i++) begin
            b1.en_n = vecs[i].en_n;
            b1.d = vecs[i].d;
            b1.mult_high = vecs[i].mult;
            b1.rd_addr = vecs[i].rd_addr;
            tick();
            check($sformatf("v%0d pending", i), b1.pending, vecs[i].exp_pend);
            check($sformatf("v%0d q[%0d]", i, vecs[i].q_idx), qw(b1.q, vecs[i].q_idx),
                  vecs[i].exp_q);
            check($sformatf("v%0d nonzero", i), nz_mask(b1.q), vecs[i].exp_nz);
            check($sformatf("v%0d rd_data", i), b1.rd_data, vecs[i].exp_rd);
            check($sformatf("v%0d ctrl", i), b1.ctrl, vecs[i].exp_ctrl);
            check($sformatf("v%0d mema_top", i), b1.mema_top, vecs[i].exp_mema);
        end
        b1.en_n = '1; b1.d = '0; b1.mult_high = '0;

        // WR_LAT=3: mult register takes mult_high after exactly 3 edges
        b3.en_n = 16'hDFFF; b3.d = 8'h11; b3.mult_high = 8'h7C;
        tick();
        b3.en_n = '1; b3.d = '0; b3.mult_high = '0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("lat3 pending +%0d", c - 1), b3.pending, 16'h2000);
            check($sformatf("lat3 q13 +%0d", c - 1), qw(b3.q, 13), 8'h00);
            tick();
        end
        check("lat3 pending done", b3.pending, 16'h0000);
        check("lat3 q13 done", qw(b3.q, 13), 8'h7C);

        // WR_LAT=3: both read ports see the commit, never the in-flight data
        b3.rd_addr = 8'h55;
        b3.en_n = 16'hFFDF; b3.d = 8'h9E;
        tick();
        b3.en_n = '1; b3.d = '0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("fwd rd_data +%0d", c - 1), b3.rd_data, 16'h0000);
            check($sformatf("fwd q5 +%0d", c - 1), qw(b3.q, 5), 8'h00);
            tick();
        end
        check("fwd rd_data commit", b3.rd_data, 16'h9E9E);
        check("fwd q5 commit", qw(b3.q, 5), 8'h9E);

        // WR_LAT=4: reset two edges after acceptance discards the write
        b4.en_n = 16'hFFFB; b4.d = 8'hFF;
        tick();
        b4.en_n = '1; b4.d = '0;
        check("mid pending +0", b4.pending, 16'h0004);
        tick();
        check("mid pending +1", b4.pending, 16'h0004);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid pending rst", b4.pending, 16'h0000);
        check("mid q2 rst", qw(b4.q, 2), 8'h00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mid q2 after %0d", c), qw(b4.q, 2), 8'h00);
            check($sformatf("mid pending after %0d", c), b4.pending, 16'h0000);
        end

        // WR_LAT=4: a fresh write after reset commits normally
        b4.en_n = 16'hFFFB; b4.d = 8'h5A;
        tick();
        b4.en_n = '1; b4.d = '0;
        tick();
        tick();
        tick();
        check("post q2 +3", qw(b4.q, 2), 8'h00);
        check("post pending +3", b4.pending, 16'h0004);
        tick();
        check("post q2 +4", qw(b4.q, 2), 8'h5A);
        check("post pending +4", b4.pending, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_pipe.md
Name: reg_file_pipe

Overview:
- Parametrised successor to the 16x8 general register file. Holds DEPTH registers of DATA_W bits.
- Writes are selected by an active-low per-register enable mask. Every register is also visible on a flat output bus.
- Adds three things:
  - configurable write-commit latency, replacing the fixed behavioural delay with a cycle-accurate pipeline;
  - a pending-write scoreboard;
  - NUM_RD addressed, registered read ports with commit forwarding.
- Dedicated taps:
  - the multiplier-high register is loaded from mult_high, not d;
  - the control and memory-address-top registers drive their own outputs.

Parameters:
- DATA_W, 8, register width in bits.
- DEPTH, 16, number of registers (>=4).
- NUM_RD, 2, number of addressed read ports (1..4).
- WR_LAT, 1, clock cycles from write acceptance to commit (1..4).
- MULT_REG, 13, index loaded from mult_high instead of d.
- MEMA_REG, 14, index driven on mema_top.
- CTRL_REG, 15, index driven on ctrl.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- d, input, DATA_W, write data for every register except MULT_REG.
- mult_high, input, DATA_W, write data for MULT_REG.
- en_n, input, DEPTH, active-low write enable per register; multiple bits may be low together.
- rd_addr, input, NUM_RD*$clog2(DEPTH), read address per port, port k in slice k.
- rd_data, output, NUM_RD*DATA_W, registered read data per port.
- pending, output, DEPTH, bit i high while a write to register i is accepted but not committed.
- q, output, DEPTH*DATA_W, committed value of every register, register i in slice i.
- ctrl, output, DATA_W, committed value of CTRL_REG.
- mema_top, output, DATA_W, committed value of MEMA_REG.

Behaviour:
- Reset, evaluated at a clk edge with rst_n=0:
  - all registers, q, ctrl, mema_top, rd_data and pending clear to 0;
  - all in-flight writes are discarded.
  - Reset has priority over everything else at that edge.
- Acceptance: at each edge with rst_n=1, the set {i : en_n[i]=0} is captured together with d and mult_high into pipeline stage 1. Each stage holds a DEPTH-bit mask plus both data words.
- Pipeline: stages advance every cycle with no stall. Stage WR_LAT commits at the next edge:
  - every masked register i != MULT_REG loads the staged d;
  - MULT_REG loads the staged mult_high.
- Latency: a write accepted at edge N is visible on q, ctrl and mema_top after edge N+WR_LAT. With WR_LAT=1 it is visible after edge N+1, i.e. the cycle following acceptance.
- Broadcast: several enables low in one cycle all commit the same staged data in the same cycle.
- Back-to-back: writes to one register in consecutive cycles commit in order; the last accepted wins. There is never reordering.
- pending[i]:
  - set when register i is captured;
  - stays high while any stage holds bit i;
  - drops after the commit edge of the last in-flight write to i.
  - It is combinational from the stage masks (OR of all stages), so it rises in the cycle after acceptance.
- Read ports:
  - rd_data[k] registers at each edge the value register rd_addr[k] will hold after that edge. This is write-first: a commit at the same edge is forwarded.
  - Read latency is 1 cycle.
  - In-flight, uncommitted data is never forwarded.
- Out-of-range rd_addr (>= DEPTH, only possible when DEPTH is not a power of 2) returns 0.
- Read ports never affect state. Simultaneous reads of the same address on all ports are legal.
- Elaboration checks (fatal):
  - WR_LAT outside 1..4 or NUM_RD outside 1..4;
  - MULT_REG, MEMA_REG or CTRL_REG >= DEPTH;
  - any two of those three equal.
- There are no combinational paths from inputs to outputs except through pending.

Decomposition:
- Shared package reg_file_pkg:
  - default DATA_W and DEPTH constants;
  - the MULT_REG, MEMA_REG and CTRL_REG index constants;
  - typedef reg_word_t (logic [DATA_W-1:0]);
  - a write-stage struct {mask, d, mult}.
- One natural sub-module: wr_stage_pipe, a WR_LAT-deep shift register of the write-stage struct with synchronous active-low clear. It exposes the commit stage and the OR of all stage masks.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> q all 0, ctrl=0, mema_top=0, pending=0, rd_data=0.
- WR_LAT=1, d=8'hA5, en_n=16'hFFFE for one cycle -> q[0]=8'hA5 one cycle later; pending[0] high for exactly one cycle; other registers stay 0.
- WR_LAT=3, en_n[13]=0 with d=8'h11 and mult_high=8'h7C -> register 13=8'h7C exactly 3 cycles after acceptance, never 8'h11; pending[13] high for 3 cycles.
- Broadcast: d=8'h3C, en_n=16'h3FFF -> ctrl=8'h3C and mema_top=8'h3C in the same cycle. Then d=8'h01 and d=8'h02 to register 15 on consecutive cycles -> ctrl goes 8'h01 then 8'h02.
- Forwarding: rd_addr[0]=5 held while a write of 8'h9E to register 5 commits -> rd_data[0]=8'h9E on the same edge q[5] updates. rd_addr[1]=5 reads 8'h9E as well.
- Reset mid-flight: WR_LAT=4, write 8'hFF to register 2, assert rst_n=0 two cycles later -> q[2] stays 0 and pending clears. A write issued after reset release commits normally.
